// File: rtl/axi_slave_mem.sv
`default_nettype none
// axi_slave_mem: byte-wide burst memory slave with independent read and write FSMs.
// Optional macro RD_WAIT_EN inserts RD_WAIT idle cycles ahead of every read beat.
module axi_slave_mem #(
  parameter int MEM_DEPTH  = 256,
  parameter int MAX_WBEATS = 16,
  parameter int RD_WAIT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ARVALID,
  input  logic [15:0] AR,
  output logic        ARREADY,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [8:0]  RD,
  output logic        RLAST,
  input  logic        AWVALID,
  input  logic [11:0] AW,
  output logic        AWREADY,
  input  logic        WVALID,
  input  logic [7:0]  WDATA,
  input  logic        WLAST,
  output logic        WREADY,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [4:0]  BRESP
);

  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WCNT_W = $clog2(MAX_WBEATS + 1);

  logic [7:0] mem [MEM_DEPTH];

  function automatic logic mapped(input logic [7:0] a);
    return ({24'd0, a} < 32'(MEM_DEPTH));
  endfunction

  // Unmapped bytes read back as zero data with SLVERR in bit 0.
  function automatic logic [8:0] rd_word(input logic [7:0] a);
    if (mapped(a)) return {mem[a[IDX_W-1:0]], 1'b0};
    return 9'h001;
  endfunction

  // ---------------------------------------------------------------- read side
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  rstate_t    r_state, r_state_n;
  logic [7:0] r_addr, r_addr_n;
  logic [4:0] r_rem, r_rem_n;
  logic       arready_n, rvalid_n, rlast_n;
  logic [8:0] rd_n;
  logic       r_next_beat, r_load;

`ifdef RD_WAIT_EN
  localparam int WAIT_W = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  logic [WAIT_W-1:0] r_wait, r_wait_n;
`endif

  always_comb begin
    r_state_n   = r_state;
    r_addr_n    = r_addr;
    r_rem_n     = r_rem;
    arready_n   = ARREADY;
    rvalid_n    = RVALID;
    rlast_n     = RLAST;
    rd_n        = RD;
    r_next_beat = 1'b0;
    r_load      = 1'b0;
`ifdef RD_WAIT_EN
    r_wait_n    = r_wait;
`endif
    unique case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (ARVALID && ARREADY) begin
          r_state_n   = R_DATA;
          arready_n   = 1'b0;
          r_addr_n    = AR[15:8];
          r_rem_n     = {1'b0, AR[7:4]} + 5'd1;
          r_next_beat = 1'b1;
        end
      end
      R_DATA: begin
        arready_n = 1'b0;
        if (RVALID && RREADY) begin
          if (r_rem == 5'd1) begin
            r_state_n = R_IDLE;
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            arready_n = 1'b1;
          end else begin
            r_addr_n    = r_addr + 8'd1;
            r_rem_n     = r_rem - 5'd1;
            r_next_beat = 1'b1;
          end
        end
`ifdef RD_WAIT_EN
        if (!RVALID) begin
          if (r_wait <= WAIT_W'(1)) r_load = 1'b1;
          else r_wait_n = r_wait - WAIT_W'(1);
        end
`endif
      end
      default: r_state_n = R_IDLE;
    endcase

    if (r_next_beat) begin
`ifdef RD_WAIT_EN
      if (RD_WAIT == 0) begin
        r_load = 1'b1;
      end else begin
        rvalid_n = 1'b0;
        rlast_n  = 1'b0;
        r_wait_n = WAIT_W'(RD_WAIT);
      end
`else
      r_load = 1'b1;
`endif
    end

    // Data is captured when the beat is launched so it stays stable while stalled.
    if (r_load) begin
      rvalid_n = 1'b1;
      rd_n     = rd_word(r_addr_n);
      rlast_n  = (r_rem_n == 5'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_addr  <= 8'd0;
      r_rem   <= 5'd0;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RD      <= 9'd0;
`ifdef RD_WAIT_EN
      r_wait  <= '0;
`endif
    end else begin
      r_state <= r_state_n;
      r_addr  <= r_addr_n;
      r_rem   <= r_rem_n;
      ARREADY <= arready_n;
      RVALID  <= rvalid_n;
      RLAST   <= rlast_n;
      RD      <= rd_n;
`ifdef RD_WAIT_EN
      r_wait  <= r_wait_n;
`endif
    end
  end

  // --------------------------------------------------------------- write side
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

  wstate_t           w_state, w_state_n;
  logic [7:0]        w_addr, w_addr_n;
  logic [3:0]        w_id, w_id_n;
  logic              w_err, w_err_n;
  logic [WCNT_W-1:0] w_cnt, w_cnt_n;
  logic              awready_n, wready_n, bvalid_n;
  logic [4:0]        bresp_n;
  logic              mem_we;
  logic              w_room;

  assign w_room = (w_cnt < WCNT_W'(MAX_WBEATS));

  always_comb begin
    w_state_n = w_state;
    w_addr_n  = w_addr;
    w_id_n    = w_id;
    w_err_n   = w_err;
    w_cnt_n   = w_cnt;
    awready_n = AWREADY;
    wready_n  = WREADY;
    bvalid_n  = BVALID;
    bresp_n   = BRESP;
    mem_we    = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        awready_n = 1'b1;
        wready_n  = 1'b0;
        if (AWVALID && AWREADY) begin
          w_state_n = W_DATA;
          awready_n = 1'b0;
          wready_n  = 1'b1;
          w_addr_n  = AW[11:4];
          w_id_n    = AW[3:0];
          w_err_n   = 1'b0;
          w_cnt_n   = '0;
        end
      end
      W_DATA: begin
        if (WVALID && WREADY) begin
          if (mapped(w_addr) && w_room) mem_we = 1'b1;
          else w_err_n = 1'b1;
          w_addr_n = w_addr + 8'd1;
          // Saturating count keeps every beat past the limit flagged as dropped.
          if (w_room) w_cnt_n = w_cnt + WCNT_W'(1);
          if (WLAST) begin
            w_state_n = W_RESP;
            wready_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = {w_id, w_err_n};
          end
        end
      end
      W_RESP: begin
        if (BVALID && BREADY) begin
          w_state_n = W_IDLE;
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_addr  <= 8'd0;
      w_id    <= 4'd0;
      w_err   <= 1'b0;
      w_cnt   <= '0;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= 5'd0;
    end else begin
      w_state <= w_state_n;
      w_addr  <= w_addr_n;
      w_id    <= w_id_n;
      w_err   <= w_err_n;
      w_cnt   <= w_cnt_n;
      AWREADY <= awready_n;
      WREADY  <= wready_n;
      BVALID  <= bvalid_n;
      BRESP   <= bresp_n;
    end
  end

  // Storage is never reset; bytes written before a reset survive it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_addr[IDX_W-1:0]] <= WDATA;
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// Bench for axi_slave_mem: directed vector table, reset corner sequences and random bursts vs a byte-array model.
module tb_axi_slave_mem;

  localparam int MEM_DEPTH  = 128;
  localparam int MAX_WBEATS = 16;
  localparam int RD_WAIT    = 2;
`ifdef RD_WAIT_EN
  localparam int LAT = 1 + RD_WAIT;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [15:0] AR;
  logic [8:0]  RD;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic [11:0] AW;
  logic [7:0]  WDATA;
  logic [4:0]  BRESP;

  axi_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .MAX_WBEATS(MAX_WBEATS), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .AR(AR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RD(RD), .RLAST(RLAST),
    .AWVALID(AWVALID), .AW(AW), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  always #5 clk = ~clk;

  logic [7:0] model_mem [256];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    int         beats;
    logic [3:0] id;
    logic [7:0] d0;
    logic [7:0] stride;
    int         hold;
    bit         use_exp;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [8:0] exp_rd(input logic [7:0] a);
    if (int'(a) < MEM_DEPTH) return {model_mem[a], 1'b0};
    return 9'h001;
  endfunction

  task automatic do_write(input logic [7:0] addr, input logic [3:0] id, input int beats,
                          input logic [7:0] d0, input logic [7:0] stride, input int bhold,
                          input bit use_exp, input logic [4:0] exp_bresp);
    logic       err;
    logic [7:0] a;
    int         cyc;
    err = 1'b0;
    for (int i = 0; i < beats; i++) begin
      a = addr + 8'(i);
      if (int'(a) < MEM_DEPTH && i < MAX_WBEATS) model_mem[a] = d0 + 8'(i) * stride;
      else err = 1'b1;
    end
    AW = {addr, id};
    AWVALID = 1'b1;
    cyc = 0;
    while (!AWREADY && cyc < 64) begin step(); cyc++; end
    check("awready", AWREADY, 1);
    step();
    AWVALID = 1'b0;
    check("awready_busy", AWREADY, 0);
    check("wready", WREADY, 1);
    for (int i = 0; i < beats; i++) begin
      if ($urandom_range(0, 3) == 0) begin WVALID = 1'b0; step(); end
      WVALID = 1'b1;
      WDATA  = d0 + 8'(i) * stride;
      WLAST  = (i == beats - 1);
      step();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    check("bvalid", BVALID, 1);
    check("wready_resp", WREADY, 0);
    check("bresp", BRESP, {id, err});
    if (use_exp) check("bresp_tab", BRESP, exp_bresp);
    for (int k = 0; k < bhold; k++) begin
      step();
      check("bvalid_hold", BVALID, 1);
      check("awready_hold", AWREADY, 0);
    end
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    check("bvalid_done", BVALID, 0);
    check("awready_idle", AWREADY, 1);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input int maxhold, input bit use_exp, input logic [8:0] exp_first);
    logic [8:0] e;
    int         cyc, h;
    AR = {addr, len, id};
    ARVALID = 1'b1;
    cyc = 0;
    while (!ARREADY && cyc < 64) begin step(); cyc++; end
    check("arready", ARREADY, 1);
    step();
    ARVALID = 1'b0;
    check("arready_busy", ARREADY, 0);
    RREADY = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      e = exp_rd(addr + 8'(i));
      cyc = 0;
      while (!RVALID && cyc < 64) begin step(); cyc++; end
      check("rvalid", RVALID, 1);
      check("r_latency", cyc, LAT - 1);
      check("rd", RD, e);
      check("rlast", RLAST, (i == int'(len)));
      if (i == 0 && use_exp) check("rd_tab", RD, exp_first);
      h = $urandom_range(0, maxhold);
      if (h > 0) begin
        RREADY = 1'b0;
        repeat (h) begin
          step();
          check("rd_stall", RD, e);
          check("rvalid_stall", RVALID, 1);
        end
        RREADY = 1'b1;
      end
      step();
    end
    RREADY = 1'b0;
    check("rvalid_done", RVALID, 0);
    check("rlast_done", RLAST, 0);
    check("arready_idle", ARREADY, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    ARVALID = 0; AR = '0; RREADY = 0; AWVALID = 0; AW = '0;
    WVALID = 0; WDATA = '0; WLAST = 0; BREADY = 0;

    vecs[0]  = '{1'b1, 8'h10,  1, 4'h3, 8'hA5, 8'h00, 0, 1'b1, 9'h006};
    vecs[1]  = '{1'b0, 8'h10,  1, 4'h7, 8'h00, 8'h00, 0, 1'b1, 9'h14A};
    vecs[2]  = '{1'b1, 8'h20,  4, 4'h1, 8'h11, 8'h11, 0, 1'b1, 9'h002};
    vecs[3]  = '{1'b0, 8'h20,  4, 4'h1, 8'h00, 8'h00, 2, 1'b1, 9'h022};
    vecs[4]  = '{1'b1, 8'h7F,  1, 4'h2, 8'h3C, 8'h00, 0, 1'b1, 9'h004};
    vecs[5]  = '{1'b0, 8'h7F,  2, 4'h0, 8'h00, 8'h00, 1, 1'b1, 9'h078};
    vecs[6]  = '{1'b1, 8'h80,  1, 4'h5, 8'h5A, 8'h00, 0, 1'b1, 9'h00B};
    vecs[7]  = '{1'b0, 8'hFE,  3, 4'h4, 8'h00, 8'h00, 1, 1'b1, 9'h001};
    vecs[8]  = '{1'b1, 8'h40, 17, 4'h9, 8'h01, 8'h11, 5, 1'b1, 9'h013};
    vecs[9]  = '{1'b0, 8'h40, 16, 4'h2, 8'h00, 8'h00, 0, 1'b1, 9'h002};
    vecs[10] = '{1'b0, 8'h50,  1, 4'h3, 8'h00, 8'h00, 0, 1'b0, 9'h000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", ARREADY, 0);
    check("rst_awready", AWREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_rd", RD, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_bresp", BRESP, 0);
    rst = 1'b1;
    check("rel_arready", ARREADY, 0);
    step();
    check("first_arready", ARREADY, 1);
    check("first_awready", AWREADY, 1);

    // Fill all mapped bytes so every later read has a known model value
    for (int b = 0; b < MEM_DEPTH; b += 16)
      do_write(8'(b), 4'(b / 16), 16, 8'($urandom), 8'($urandom_range(1, 255)), 0, 1'b0, 5'd0);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].is_wr)
        do_write(vecs[v].addr, vecs[v].id, vecs[v].beats, vecs[v].d0, vecs[v].stride,
                 vecs[v].hold, vecs[v].use_exp, vecs[v].exp[4:0]);
      else
        do_read(vecs[v].addr, 4'(vecs[v].beats - 1), vecs[v].id, vecs[v].hold,
                vecs[v].use_exp, vecs[v].exp);
    end

    // Reset during beat 2 of an 8-beat read
    AR = {8'h00, 4'd7, 4'd0};
    ARVALID = 1'b1;
    cyc = 0;
    while (!ARREADY && cyc < 64) begin step(); cyc++; end
    check("mr_arready", ARREADY, 1);
    step();
    ARVALID = 1'b0;
    RREADY = 1'b1;
    cyc = 0;
    while (!RVALID && cyc < 64) begin step(); cyc++; end
    check("mr_beat1", RVALID, 1);
    step();
    cyc = 0;
    while (!RVALID && cyc < 64) begin step(); cyc++; end
    check("mr_beat2", RVALID, 1);
    check("mr_rd2", RD, {model_mem[1], 1'b0});
    rst = 1'b0;
    #1;
    check("mr_rvalid_async", RVALID, 0);
    check("mr_arready_async", ARREADY, 0);
    check("mr_rlast_async", RLAST, 0);
    RREADY = 1'b0;
    step();
    check("mr_arready_held", ARREADY, 0);
    rst = 1'b1;
    step();
    check("mr_arready_rel", ARREADY, 1);
    check("mr_awready_rel", AWREADY, 1);
    check("mr_rvalid_rel", RVALID, 0);

    // Reset after two beats of a write: those bytes stay, no response appears
    AW = {8'h30, 4'h6};
    AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    check("mw_wready", WREADY, 1);
    WVALID = 1'b1; WDATA = 8'hC1; WLAST = 1'b0;
    step();
    WDATA = 8'hC2;
    step();
    WVALID = 1'b0;
    model_mem[8'h30] = 8'hC1;
    model_mem[8'h31] = 8'hC2;
    rst = 1'b0;
    #1;
    check("mw_bvalid", BVALID, 0);
    check("mw_wready_rst", WREADY, 0);
    step();
    rst = 1'b1;
    step();
    check("mw_awready", AWREADY, 1);
    check("mw_bvalid_rel", BVALID, 0);
    do_read(8'h30, 4'd3, 4'd0, 1, 1'b1, 9'h182);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(8'($urandom_range(0, 255)), 4'($urandom), int'($urandom_range(1, 18)),
                 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0, 5'd0);
      else
        do_read(8'($urandom_range(0, 255)), 4'($urandom), 4'($urandom), 2, 1'b0, 9'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
